// File: rtl/ml_accel_pkg.sv
// Shared constants and the DMA scheduler state encoding.
package ml_accel_pkg;

   localparam int DMA_BEAT_BYTES = 16;
   localparam int DMA_MAX_BURST  = 16;
   localparam int DMA_PAGE_BYTES = 4096;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } dma_state_e;

endpackage

// File: rtl/dma_burst_len_calc.sv
// Burst length for the next AR: min(remaining beats, MAX_BURST) and, when
// DMA_SCHED_4K_SPLIT_EN is defined, also the beats left before the next
// 4 KB page boundary so no burst straddles a page.
module dma_burst_len_calc
   import ml_accel_pkg::*;
#(
   parameter int BEAT_BYTES = DMA_BEAT_BYTES,
   parameter int MAX_BURST  = DMA_MAX_BURST
) (
`ifdef DMA_SCHED_4K_SPLIT_EN
   input  logic [$clog2(DMA_PAGE_BYTES)-1:0] page_off,
`endif
   input  logic [31:0]                       remaining_beats,
   output logic [31:0]                       len
);

   localparam int PAGE_W = $clog2(DMA_PAGE_BYTES);

   logic [31:0] burst_cap;

   // Clamp the remaining transfer to the largest allowed burst.
   always_comb begin
      burst_cap = remaining_beats;
      if (remaining_beats > 32'(MAX_BURST)) begin
         burst_cap = 32'(MAX_BURST);
      end
   end

`ifdef DMA_SCHED_4K_SPLIT_EN
   logic [PAGE_W:0] page_left;
   logic [31:0]     page_beats;

   // Beats that fit between the current address and the next page boundary.
   always_comb begin
      page_left  = (PAGE_W+1)'(DMA_PAGE_BYTES) - {1'b0, page_off};
      page_beats = 32'(page_left / (PAGE_W+1)'(BEAT_BYTES));
      len        = (page_beats < burst_cap) ? page_beats : burst_cap;
   end
`else
   // Without page splitting the clamped length is the burst length.
   always_comb begin
      len = burst_cap;
   end
`endif

endmodule

// File: rtl/dma_burst_scheduler.sv
// DMA read burst scheduler: splits an aligned transfer into AXI AR bursts,
// keeps at most MAX_OUTSTANDING bursts in flight and reports done/error once
// every issued burst has returned its last beat.
// Optional feature macro: DMA_SCHED_4K_SPLIT_EN (no burst crosses 4 KB).
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing AR bursts while beats remain
// DRAIN | all ARs issued, waiting for outstanding rlast beats
// DONE  | one-cycle done pulse
// ERR   | one-cycle error pulse (bad alignment or error response)
module dma_burst_scheduler
   import ml_accel_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int BEAT_BYTES      = DMA_BEAT_BYTES,
   parameter int MAX_BURST       = DMA_MAX_BURST,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [31:0]       size_bytes,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic [7:0]        m_axi_arlen,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic              m_axi_rvalid,
   input  logic              m_axi_rready,
   input  logic              m_axi_rlast,
   input  logic [1:0]        m_axi_rresp
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   dma_state_e        state, state_nxt;
   logic [ADDR_W-1:0] cur_addr;
   logic [31:0]       remaining_beats;
   logic [OUT_W-1:0]  outstanding;
   logic              err_flag;
   logic [31:0]       len;
   logic              misaligned;
   logic              accept_xfer;
   logic              ar_hs;
   logic              r_hs;
   logic              r_last_hs;

   dma_burst_len_calc #(
      .BEAT_BYTES (BEAT_BYTES),
      .MAX_BURST  (MAX_BURST)
   ) u_len_calc (
`ifdef DMA_SCHED_4K_SPLIT_EN
      .page_off        (cur_addr[$clog2(DMA_PAGE_BYTES)-1:0]),
`endif
      .remaining_beats (remaining_beats),
      .len             (len)
   );

   assign misaligned  = ((base_addr % ADDR_W'(BEAT_BYTES)) != '0) ||
                        ((size_bytes % 32'(BEAT_BYTES)) != '0);
   assign accept_xfer = (state == IDLE) && start && !misaligned && (size_bytes != '0);
   assign ar_hs       = m_axi_arvalid && m_axi_arready;
   assign r_hs        = m_axi_rvalid && m_axi_rready;
   assign r_last_hs   = r_hs && m_axi_rlast;

   // AR address/length only reflect the burst while it is offered, zero otherwise.
   assign m_axi_araddr = m_axi_arvalid ? cur_addr : '0;
   assign m_axi_arlen  = m_axi_arvalid ? 8'(len - 32'd1) : '0;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nxt     = state;
      busy          = 1'b0;
      done          = 1'b0;
      error         = 1'b0;
      m_axi_arvalid = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (misaligned) begin
                  state_nxt = ERR;
               end else if (size_bytes == '0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            busy          = 1'b1;
            m_axi_arvalid = (outstanding < OUT_W'(MAX_OUTSTANDING));
            if (m_axi_arvalid && m_axi_arready && (len == remaining_beats)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (outstanding == '0) begin
               state_nxt = err_flag ? ERR : DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         ERR: begin
            error     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Transfer progress, in-flight burst count and sticky response error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_addr        <= '0;
         remaining_beats <= '0;
         outstanding     <= '0;
         err_flag        <= 1'b0;
      end else begin
         if (accept_xfer) begin
            cur_addr        <= base_addr;
            remaining_beats <= size_bytes / 32'(BEAT_BYTES);
         end else if (ar_hs) begin
            cur_addr        <= cur_addr + ADDR_W'(len) * ADDR_W'(BEAT_BYTES);
            remaining_beats <= remaining_beats - len;
         end

         if (ar_hs && !r_last_hs) begin
            outstanding <= outstanding + 1'b1;
         end else if (!ar_hs && r_last_hs && (outstanding != '0)) begin
            outstanding <= outstanding - 1'b1;
         end

         if ((state == DONE) || (state == ERR)) begin
            err_flag <= 1'b0;
         end else if (r_hs && (m_axi_rresp != 2'b00)) begin
            err_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dma_burst_scheduler.sv
// Directed bench for dma_burst_scheduler with hand-computed AR sequences.
module tb_dma_burst_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] base_addr;
   logic [31:0] size_bytes;
   logic        busy, done, error;
   logic [31:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;
   logic [1:0]  m_axi_rresp;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] ar_addr_q[$];
   logic [7:0]  ar_len_q[$];
   int          done_cnt = 0;
   int          err_cnt  = 0;
   int          d0, e0;

   always #5 clk = ~clk;

   dma_burst_scheduler #(
      .ADDR_W          (32),
      .BEAT_BYTES      (16),
      .MAX_BURST       (16),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .base_addr     (base_addr),
      .size_bytes    (size_bytes),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rresp   (m_axi_rresp)
   );

   // Record AR handshakes and completion pulses mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_axi_arvalid && m_axi_arready) begin
            ar_addr_q.push_back(m_axi_araddr);
            ar_len_q.push_back(m_axi_arlen);
         end
         if (done)  done_cnt++;
         if (error) err_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_xfer(input logic [31:0] base, input logic [31:0] size);
      base_addr  = base;
      size_bytes = size;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_ars(input int n, input int budget, input string tag);
      int c = 0;
      while (ar_addr_q.size() < n && c < budget) begin
         tick();
         c++;
      end
      chk(tag, 64'(ar_addr_q.size()), 64'(n));
   endtask

   task automatic wait_end(input int budget);
      int c = 0;
      int s0 = done_cnt + err_cnt;
      while ((done_cnt + err_cnt) == s0 && c < budget) begin
         tick();
         c++;
      end
      if (c >= budget) chk("end_timeout", 64'(c), 64'(0));
      tick();
   endtask

   task automatic respond(input int beats, input logic [1:0] resp);
      for (int i = 0; i < beats; i++) begin
         m_axi_rvalid = 1'b1;
         m_axi_rready = 1'b1;
         m_axi_rlast  = (i == beats - 1);
         m_axi_rresp  = resp;
         tick();
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
   endtask

   task automatic clear_q();
      ar_addr_q.delete();
      ar_len_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0; size_bytes = '0;
      m_axi_arready = 1'b1; m_axi_rvalid = 1'b0; m_axi_rready = 1'b0;
      m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
      repeat (3) tick();
      chk("rst_busy",    64'(busy), 64'(0));
      chk("rst_done",    64'(done), 64'(0));
      chk("rst_error",   64'(error), 64'(0));
      chk("rst_arvalid", 64'(m_axi_arvalid), 64'(0));
      chk("rst_araddr",  64'(m_axi_araddr), 64'(0));
      chk("rst_arlen",   64'(m_axi_arlen), 64'(0));
      rst_n = 1'b1;
      tick();

      // 32 beats from 0x1000: two full bursts.
      clear_q(); d0 = done_cnt; e0 = err_cnt;
      start_xfer(32'h1000, 32'd512);
      wait_ars(2, 20, "t1_ar_count");
      chk("t1_addr0", 64'(ar_addr_q[0]), 64'h1000);
      chk("t1_len0",  64'(ar_len_q[0]), 64'd15);
      chk("t1_addr1", 64'(ar_addr_q[1]), 64'h1100);
      chk("t1_len1",  64'(ar_len_q[1]), 64'd15);
      start_xfer(32'h1004, 32'd64);
      chk("t1_busy", 64'(busy), 64'(1));
      respond(16, 2'b00);
      respond(16, 2'b00);
      wait_end(20);
      chk("t1_done", 64'(done_cnt - d0), 64'(1));
      chk("t1_noerr", 64'(err_cnt - e0), 64'(0));
      chk("t1_idle_busy", 64'(busy), 64'(0));

      // 4 beats at 0x0FE0, straddling a page; arready held off first.
      clear_q(); d0 = done_cnt;
      m_axi_arready = 1'b0;
      start_xfer(32'h0FE0, 32'd64);
      repeat (3) tick();
      chk("t2_hold_valid", 64'(m_axi_arvalid), 64'(1));
      chk("t2_hold_addr",  64'(m_axi_araddr), 64'h0FE0);
`ifdef DMA_SCHED_4K_SPLIT_EN
      chk("t2_hold_len",   64'(m_axi_arlen), 64'd1);
      m_axi_arready = 1'b1;
      wait_ars(2, 20, "t2_ar_count");
      chk("t2_addr0", 64'(ar_addr_q[0]), 64'h0FE0);
      chk("t2_len0",  64'(ar_len_q[0]), 64'd1);
      chk("t2_addr1", 64'(ar_addr_q[1]), 64'h1000);
      chk("t2_len1",  64'(ar_len_q[1]), 64'd1);
      respond(2, 2'b00);
      respond(2, 2'b00);
`else
      chk("t2_hold_len",   64'(m_axi_arlen), 64'd3);
      m_axi_arready = 1'b1;
      wait_ars(1, 20, "t2_ar_count");
      repeat (3) tick();
      chk("t2_single", 64'(ar_addr_q.size()), 64'd1);
      chk("t2_addr0", 64'(ar_addr_q[0]), 64'h0FE0);
      chk("t2_len0",  64'(ar_len_q[0]), 64'd3);
      respond(4, 2'b00);
`endif
      wait_end(20);
      chk("t2_done", 64'(done_cnt - d0), 64'(1));

      // 96 beats with no read data: outstanding limit of 4.
      clear_q(); d0 = done_cnt;
      start_xfer(32'h2000, 32'd1536);
      wait_ars(4, 20, "t3_ar_count4");
      repeat (10) tick();
      chk("t3_still4",  64'(ar_addr_q.size()), 64'd4);
      chk("t3_arvalid", 64'(m_axi_arvalid), 64'(0));
      respond(16, 2'b00);
      wait_ars(5, 10, "t3_ar_count5");
      chk("t3_addr4", 64'(ar_addr_q[4]), 64'h2400);
      respond(16, 2'b00);
      wait_ars(6, 10, "t3_ar_count6");
      chk("t3_addr5", 64'(ar_addr_q[5]), 64'h2500);
      repeat (4) respond(16, 2'b00);
      wait_end(20);
      chk("t3_done", 64'(done_cnt - d0), 64'(1));

      // Rejected and empty starts.
      clear_q(); e0 = err_cnt; d0 = done_cnt;
      start_xfer(32'h1004, 32'd64);
      chk("t4_err_addr", 64'(error), 64'(1));
      chk("t4_err_addr_arv", 64'(m_axi_arvalid), 64'(0));
      tick();
      chk("t4_err_pulse_end", 64'(error), 64'(0));
      start_xfer(32'h1000, 32'd20);
      chk("t4_err_size", 64'(error), 64'(1));
      tick();
      start_xfer(32'h1000, 32'd0);
      chk("t4_done_zero", 64'(done), 64'(1));
      chk("t4_busy_zero", 64'(busy), 64'(0));
      tick(); tick();
      chk("t4_no_ar",  64'(ar_addr_q.size()), 64'd0);
      chk("t4_errcnt", 64'(err_cnt - e0), 64'd2);
      chk("t4_donecnt", 64'(done_cnt - d0), 64'd1);

      // Error response on first of three bursts.
      clear_q(); e0 = err_cnt; d0 = done_cnt;
      start_xfer(32'h3000, 32'd768);
      wait_ars(3, 20, "t5_ar_count");
      respond(16, 2'b10);
      respond(16, 2'b00);
      respond(16, 2'b00);
      wait_end(20);
      chk("t5_ar_total", 64'(ar_addr_q.size()), 64'd3);
      chk("t5_error", 64'(err_cnt - e0), 64'd1);
      chk("t5_nodone", 64'(done_cnt - d0), 64'd0);

      // Reset while draining two bursts, then a clean transfer.
      clear_q(); e0 = err_cnt; d0 = done_cnt;
      start_xfer(32'h4000, 32'd512);
      wait_ars(2, 20, "t6_ar_count");
      tick(); tick();
      rst_n = 1'b0;
      tick();
      chk("t6_busy",    64'(busy), 64'(0));
      chk("t6_arvalid", 64'(m_axi_arvalid), 64'(0));
      chk("t6_araddr",  64'(m_axi_araddr), 64'(0));
      rst_n = 1'b1;
      repeat (3) tick();
      chk("t6_no_pulse", 64'((done_cnt - d0) + (err_cnt - e0)), 64'd0);
      clear_q();
      start_xfer(32'h5000, 32'd256);
      wait_ars(1, 20, "t6_new_ar");
      chk("t6_new_addr", 64'(ar_addr_q[0]), 64'h5000);
      chk("t6_new_len",  64'(ar_len_q[0]), 64'd15);
      respond(16, 2'b00);
      wait_end(20);
      chk("t6_new_done", 64'(done_cnt - d0), 64'd1);
      chk("t6_new_noerr", 64'(err_cnt - e0), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dma_burst_scheduler.md
DMA_BURST_SCHEDULER -- requirements
Module: dma_burst_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter BEAT_BYTES, default 16, bytes per data beat (128-bit bus).
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per burst (1..256).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, maximum issued-but-incomplete bursts.
REQ-005 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle transfer request.
REQ-008 SHALL have port base_addr  input  ADDR_W  transfer start byte address, sampled on accepted start.
REQ-009 SHALL have port size_bytes  input  32  transfer length in bytes, sampled on accepted start.
REQ-010 SHALL have port busy  output  1  high from the cycle after an accepted start until done or error.
REQ-011 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-012 SHALL have port error  output  1  one-cycle pulse on failed completion.
REQ-013 SHALL have port m_axi_araddr / m_axi_arlen / m_axi_arvalid  output  ADDR_W/8/1  AR channel.
REQ-014 SHALL have port m_axi_arready  input  1  AR channel ready.
REQ-015 SHALL have port m_axi_rvalid / m_axi_rready / m_axi_rlast  input  1/1/1  R handshake monitor.
REQ-016 SHALL have port m_axi_rresp  input  2  read response monitor.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, DRAIN, DONE and ERR.
REQ-018 SHALL accept start only in IDLE and ignore it in every other state.
REQ-019 SHALL go from IDLE to ERR on start if base_addr or size_bytes is not a multiple of BEAT_BYTES, with no AR issued.
REQ-020 SHALL go from IDLE to DONE on start if size_bytes==0, with no AR issued.
REQ-021 SHALL otherwise go to ISSUE with remaining_beats = size_bytes/BEAT_BYTES and cur_addr = base_addr.
REQ-022 SHALL compute each burst as len = min(remaining_beats, MAX_BURST, beats to next 4 KB boundary when the split is enabled), and drive arlen = len-1.
REQ-023 SHALL assert arvalid in ISSUE only when outstanding < MAX_OUTSTANDING.
REQ-024 SHALL hold araddr and arlen stable while arvalid=1 and arready=0.
REQ-025 SHALL, on an AR handshake, advance cur_addr by len*BEAT_BYTES and subtract len from remaining_beats.
REQ-026 SHALL go to DRAIN when remaining_beats reaches 0.
REQ-027 SHALL increment outstanding on an AR handshake and decrement it on an R handshake with rlast; both in the same cycle SHALL leave it unchanged.
REQ-028 SHALL set a sticky err_flag on any R handshake with rresp!=0.
REQ-029 SHALL continue issuing after err_flag is set, so that every issued burst is drained.
REQ-030 SHALL leave DRAIN when outstanding==0, going to ERR if err_flag is set and to DONE otherwise.
REQ-031 SHALL spend one cycle in DONE with done=1 and one cycle in ERR with error=1, then return to IDLE, clearing err_flag.
REQ-032 SHALL treat a combinational arready with arvalid as a handshake in that cycle; the next burst SHALL appear no earlier than the following cycle.

Reset
REQ-033 SHALL, on rst_n=0 at a clock edge, go to IDLE.
REQ-034 SHALL, on reset, clear outstanding, remaining_beats and err_flag.
REQ-035 SHALL, on reset, drive arvalid, busy, done, error, araddr and arlen to 0.
REQ-036 SHALL abandon any in-flight transfer on reset mid-operation, with no done or error pulse.

Configuration
REQ-037 SHALL, with macro DMA_SCHED_4K_SPLIT_EN defined, never issue a burst that crosses a 4096-byte address boundary.
REQ-038 SHALL, without DMA_SCHED_4K_SPLIT_EN, limit bursts only by MAX_BURST and remaining_beats.

Structure
REQ-039 SHALL take the state enum, BEAT_BYTES, MAX_BURST and the 4 KB constant from shared package ml_accel_pkg.
REQ-040 SHALL compute burst length in one combinational sub-module, dma_burst_len_calc, instantiated once.

Verification
REQ-041 SHALL cover: base 0x1000, size 512 (32 beats), arready=1 -> two ARs, araddr 0x1000 arlen 15 then 0x1100 arlen 15; done after both rlast.
REQ-042 SHALL cover: base 0x0FE0, size 64, split enabled -> ARs 0x0FE0 arlen 1 then 0x1000 arlen 1; split disabled -> single AR 0x0FE0 arlen 3.
REQ-043 SHALL cover: size 16*16*6, rvalid held low -> exactly 4 ARs outstanding, arvalid low until one rlast arrives, then fifth AR issued.
REQ-044 SHALL cover: base 0x1004 or size 20 -> error pulse 1 cycle after start, no arvalid; size 0 -> done pulse, no arvalid.
REQ-045 SHALL cover: rresp=2 on the first burst of a 3-burst transfer -> all 3 bursts still issued and drained, then error pulse and no done.
REQ-046 SHALL cover: rst_n low during DRAIN with 2 outstanding -> next cycle IDLE, busy=0, arvalid=0; a new start then works normally.
